// File: rtl/rhd_axil_cfg_slave.sv
`default_nettype none
// ============================================================================
// Module      : rhd_axil_cfg_slave
// Description : AXI4-Lite register file for the RHD acquisition controller.
//               CTRL (0x0), MISO_DELAY (0x4), PKT_LEN (0x8), STATUS (0xC).
//               Drives static configuration and RUN start/stop pulses into
//               the RHD SPI sequencer and collects its status.
// Ports       : aclk/areset         - clock, synchronous active-high reset
//               s_axi_*             - AXI4-Lite responder interface
//               cfg_*               - configuration register outputs
//               start/stop_pulse    - one-cycle pulses on RUN edges
//               sts_busy/overflow   - sequencer status inputs
// Revision    : 1.0 - initial release
// ============================================================================
module rhd_axil_cfg_slave #(
    parameter int          C_ADDR_WIDTH  = 5,
    parameter logic [31:0] DELAY_RESET   = 32'h0000_0000,
    parameter logic [15:0] PKT_LEN_RESET = 16'd1
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [C_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [31:0]             s_axi_wdata,
    input  logic [3:0]              s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [C_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [31:0]             s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic                    cfg_run,
    output logic                    cfg_fast_settle,
    output logic                    cfg_dsp_en,
    output logic                    cfg_loopback,
    output logic [31:0]             cfg_miso_delay,
    output logic [15:0]             cfg_pkt_len,
    output logic                    start_pulse,
    output logic                    stop_pulse,
    input  logic                    sts_busy,
    input  logic                    sts_overflow
);

    localparam logic [1:0]  c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  c_RESP_SLVERR = 2'b10;
    localparam logic [31:0] c_CTRL_MASK   = 32'h0000_0017;

    // Write-channel holders and response
    logic        aw_held_q;
    logic [2:0]  aw_addr_q;     // {addr[4], addr[3:2]}
    logic        w_held_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    // Read-channel response
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    // Register file
    logic [31:0] ctrl_q,  ctrl_d;
    logic [31:0] delay_q, delay_d;
    logic [15:0] pkt_q,   pkt_d;
    logic        ovf_q,   ovf_d;
    logic        lockerr_q, lockerr_d;
    logic        run_prev_q, start_q, stop_q;

    logic        w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_commit;
    logic [31:0] w_wr_old, w_merged;
    logic [1:0]  bresp_d;
    logic        w_lock_set, w_ovf_clr, w_lock_clr;
    logic [31:0] rdata_d;
    logic [1:0]  rresp_d;

    // Protection bits and the byte-lane address bits carry no meaning here
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, s_axi_awprot, s_axi_arprot,
                           s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return r;
    endfunction

    // Ready is held low during reset so the master never sees a handshake then
    assign s_axi_awready = ~areset & ~aw_held_q & ~bvalid_q;
    assign s_axi_wready  = ~areset & ~w_held_q  & ~bvalid_q;
    assign s_axi_arready = ~areset & ~rvalid_q;

    assign w_aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_w_hs   = s_axi_wvalid  & s_axi_wready;
    assign w_ar_hs  = s_axi_arvalid & s_axi_arready;
    assign w_b_hs   = bvalid_q & s_axi_bready;
    // Holders stay set while B is pending, so gate on ~bvalid to commit once
    assign w_commit = aw_held_q & w_held_q & ~bvalid_q;

    always_comb begin
        w_wr_old = ctrl_q;
        case (aw_addr_q[1:0])
            2'd1:    w_wr_old = delay_q;
            2'd2:    w_wr_old = {16'h0000, pkt_q};
            default: w_wr_old = ctrl_q;
        endcase
    end
    assign w_merged = f_merge(w_wr_old, wdata_q, wstrb_q);

    always_comb begin
        ctrl_d     = ctrl_q;
        delay_d    = delay_q;
        pkt_d      = pkt_q;
        bresp_d    = c_RESP_OKAY;
        w_lock_set = 1'b0;
        w_ovf_clr  = 1'b0;
        w_lock_clr = 1'b0;
        if (w_commit) begin
            if (aw_addr_q[2]) begin
                bresp_d = c_RESP_SLVERR;
            end else begin
                case (aw_addr_q[1:0])
                    2'd0: ctrl_d = w_merged & c_CTRL_MASK;
                    2'd1, 2'd2: begin
                        // Timing/packet config is frozen while acquiring
                        if (ctrl_q[0]) begin
                            bresp_d    = c_RESP_SLVERR;
                            w_lock_set = 1'b1;
                        end else if (aw_addr_q[1:0] == 2'd1) begin
                            delay_d = w_merged;
                        end else begin
                            pkt_d = (w_merged[15:0] == 16'd0) ? 16'd1 : w_merged[15:0];
                        end
                    end
                    default: begin
                        w_ovf_clr  = wstrb_q[0] & wdata_q[1];
                        w_lock_clr = wstrb_q[0] & wdata_q[2];
                    end
                endcase
            end
        end
        // A set arriving with a clear wins
        ovf_d     = (ovf_q & ~w_ovf_clr) | sts_overflow;
        lockerr_d = (lockerr_q & ~w_lock_clr) | w_lock_set;
    end

    always_comb begin
        rdata_d = 32'h0;
        rresp_d = c_RESP_OKAY;
        if (s_axi_araddr[4]) begin
            rresp_d = c_RESP_SLVERR;
        end else begin
            case (s_axi_araddr[3:2])
                2'd0:    rdata_d = ctrl_q;
                2'd1:    rdata_d = delay_q;
                2'd2:    rdata_d = {16'h0000, pkt_q};
                default: rdata_d = {29'h0, lockerr_q, ovf_q, sts_busy};
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            aw_held_q  <= 1'b0;
            aw_addr_q  <= 3'd0;
            w_held_q   <= 1'b0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            bvalid_q   <= 1'b0;
            bresp_q    <= c_RESP_OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= 32'h0;
            rresp_q    <= c_RESP_OKAY;
            ctrl_q     <= 32'h0;
            delay_q    <= DELAY_RESET;
            pkt_q      <= PKT_LEN_RESET;
            ovf_q      <= 1'b0;
            lockerr_q  <= 1'b0;
            run_prev_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                aw_held_q <= 1'b1;
                aw_addr_q <= s_axi_awaddr[4:2];
            end
            if (w_w_hs) begin
                w_held_q <= 1'b1;
                wdata_q  <= s_axi_wdata;
                wstrb_q  <= s_axi_wstrb;
            end
            if (w_commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= bresp_d;
            end else if (w_b_hs) begin
                bvalid_q  <= 1'b0;
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end
            if (w_ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
                rresp_q  <= rresp_d;
            end else if (rvalid_q && s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
            ctrl_q     <= ctrl_d;
            delay_q    <= delay_d;
            pkt_q      <= pkt_d;
            ovf_q      <= ovf_d;
            lockerr_q  <= lockerr_d;
            // RUN edge seen one cycle after the commit that changed it
            run_prev_q <= ctrl_q[0];
            start_q    <= ctrl_q[0] & ~run_prev_q;
            stop_q     <= ~ctrl_q[0] & run_prev_q;
        end
    end

    assign s_axi_bvalid    = bvalid_q;
    assign s_axi_bresp     = bresp_q;
    assign s_axi_rvalid    = rvalid_q;
    assign s_axi_rdata     = rdata_q;
    assign s_axi_rresp     = rresp_q;
    assign cfg_run         = ctrl_q[0];
    assign cfg_fast_settle = ctrl_q[1];
    assign cfg_dsp_en      = ctrl_q[2];
    assign cfg_loopback    = ctrl_q[4];
    assign cfg_miso_delay  = delay_q;
    assign cfg_pkt_len     = pkt_q;
    assign start_pulse     = start_q;
    assign stop_pulse      = stop_q;

endmodule
`default_nettype wire

// File: tb/tb_rhd_axil_cfg_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_rhd_axil_cfg_slave
// Description : Self-checking bench for rhd_axil_cfg_slave. Directed AXI-Lite
//               sequences plus randomized traffic checked against a
//               register-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rhd_axil_cfg_slave;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [4:0]  s_axi_awaddr = '0;
    logic [2:0]  s_axi_awprot = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [4:0]  s_axi_araddr = '0;
    logic [2:0]  s_axi_arprot = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic        cfg_run, cfg_fast_settle, cfg_dsp_en, cfg_loopback;
    logic [31:0] cfg_miso_delay;
    logic [15:0] cfg_pkt_len;
    logic        start_pulse, stop_pulse;
    logic        sts_busy = 1'b0;
    logic        sts_overflow = 1'b0;

    rhd_axil_cfg_slave dut (
        .aclk(aclk), .areset(areset),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .cfg_run(cfg_run), .cfg_fast_settle(cfg_fast_settle),
        .cfg_dsp_en(cfg_dsp_en), .cfg_loopback(cfg_loopback),
        .cfg_miso_delay(cfg_miso_delay), .cfg_pkt_len(cfg_pkt_len),
        .start_pulse(start_pulse), .stop_pulse(stop_pulse),
        .sts_busy(sts_busy), .sts_overflow(sts_overflow)
    );

    always #5 aclk = ~aclk;

    int n_total = 0;
    int n_pass  = 0;
    int start_cnt = 0;
    int stop_cnt  = 0;

    always @(negedge aclk) begin
        if (start_pulse === 1'b1) start_cnt++;
        if (stop_pulse === 1'b1) stop_cnt++;
    end

    // Reference model state
    logic [31:0] m_ctrl, m_delay;
    logic [15:0] m_pkt;
    logic        m_ovf, m_lock;

    task automatic model_reset();
        m_ctrl = 32'h0; m_delay = 32'h0; m_pkt = 16'd1; m_ovf = 1'b0; m_lock = 1'b0;
    endtask

    function automatic logic [1:0] model_write(input logic [4:0] a, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] old, m;
        old = (a[3:2] == 2'd1) ? m_delay : (a[3:2] == 2'd2) ? {16'h0, m_pkt} : m_ctrl;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = s[i] ? d[8*i +: 8] : old[8*i +: 8];
        if (a[4]) return 2'b10;
        case (a[3:2])
            2'd0: m_ctrl = m & 32'h17;
            2'd1, 2'd2: begin
                if (m_ctrl[0]) begin
                    m_lock = 1'b1;
                    return 2'b10;
                end
                if (a[3:2] == 2'd1) m_delay = m;
                else m_pkt = (m[15:0] == 16'd0) ? 16'd1 : m[15:0];
            end
            default: begin
                if (s[0] && d[1]) m_ovf = 1'b0;
                if (s[0] && d[2]) m_lock = 1'b0;
            end
        endcase
        return 2'b00;
    endfunction

    function automatic logic [33:0] model_read(input logic [4:0] a);
        if (a[4]) return {2'b10, 32'h0};
        case (a[3:2])
            2'd0:    return {2'b00, m_ctrl};
            2'd1:    return {2'b00, m_delay};
            2'd2:    return {2'b00, 16'h0, m_pkt};
            default: return {2'b00, 29'h0, m_lock, m_ovf, sts_busy};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    endtask

    task automatic chk_cfg(input string tag);
        chk({tag, "_ctrl"}, {27'h0, cfg_loopback, 1'b0, cfg_dsp_en, cfg_fast_settle, cfg_run},
            m_ctrl);
        chk({tag, "_delay"}, cfg_miso_delay, m_delay);
        chk({tag, "_pkt"}, {16'h0, cfg_pkt_len}, {16'h0, m_pkt});
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly,
                            input string tag);
        bit awd, wdn, awh, wh, run_before;
        int c, st0, sp0;
        logic [1:0] exp_resp;
        awd = 0; wdn = 0; c = 0;
        st0 = start_cnt; sp0 = stop_cnt;
        s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s;
        while (!(awd && wdn) && c < 40) begin
            s_axi_awvalid = !awd && (c >= aw_dly);
            s_axi_wvalid  = !wdn && (c >= w_dly);
            awh = s_axi_awvalid && s_axi_awready;
            wh  = s_axi_wvalid && s_axi_wready;
            @(posedge aclk); #1;
            if (awh) awd = 1;
            if (wh)  wdn = 1;
            c++;
            if (awd != wdn) chk({tag, "_early_bvalid"}, {31'h0, s_axi_bvalid}, 32'h0);
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        chk({tag, "_hs_done"}, {31'h0, awd && wdn}, 32'h1);
        if (!(awd && wdn)) return;
        run_before = m_ctrl[0];
        exp_resp = model_write(a, d, s);
        chk({tag, "_bvalid_pre"}, {31'h0, s_axi_bvalid}, 32'h0);
        @(posedge aclk); #1;
        chk({tag, "_bvalid"}, {31'h0, s_axi_bvalid}, 32'h1);
        chk({tag, "_bresp"}, {30'h0, s_axi_bresp}, {30'h0, exp_resp});
        chk_cfg(tag);
        chk({tag, "_pulse_early"}, {30'h0, start_pulse, stop_pulse}, 32'h0);
        for (int k = 0; k < b_dly; k++) begin
            @(posedge aclk); #1;
            chk({tag, "_bhold"}, {28'h0, s_axi_bvalid, s_axi_awready, s_axi_wready, 1'b0},
                32'h8);
            chk({tag, "_bresp_hold"}, {30'h0, s_axi_bresp}, {30'h0, exp_resp});
            if (k == 0)
                chk({tag, "_pulse"}, {30'h0, start_pulse, stop_pulse},
                    {30'h0, !run_before && m_ctrl[0], run_before && !m_ctrl[0]});
        end
        s_axi_bready = 1'b1;
        @(posedge aclk); #1;
        s_axi_bready = 1'b0;
        chk({tag, "_bdone"}, {31'h0, s_axi_bvalid}, 32'h0);
        @(posedge aclk); #1;
        chk({tag, "_pulse_cnt"}, (start_cnt - st0) * 2 + (stop_cnt - sp0),
            (!run_before && m_ctrl[0]) ? 32'd2 : (run_before && !m_ctrl[0]) ? 32'd1 : 32'd0);
    endtask

    task automatic do_read(input logic [4:0] a, input int ar_dly, input int r_dly,
                           input string tag);
        bit ard, arh;
        int c;
        logic [33:0] exp;
        ard = 0; c = 0;
        s_axi_araddr = a;
        exp = model_read(a);
        while (!ard && c < 40) begin
            s_axi_arvalid = (c >= ar_dly);
            arh = s_axi_arvalid && s_axi_arready;
            @(posedge aclk); #1;
            if (arh) ard = 1;
            c++;
        end
        s_axi_arvalid = 1'b0;
        chk({tag, "_ar_done"}, {31'h0, ard}, 32'h1);
        if (!ard) return;
        chk({tag, "_rvalid"}, {31'h0, s_axi_rvalid}, 32'h1);
        chk({tag, "_rdata"}, s_axi_rdata, exp[31:0]);
        chk({tag, "_rresp"}, {30'h0, s_axi_rresp}, {30'h0, exp[33:32]});
        for (int k = 0; k < r_dly; k++) begin
            @(posedge aclk); #1;
            chk({tag, "_rhold"}, {s_axi_rvalid, s_axi_arready, s_axi_rdata[29:0]},
                {2'b10, exp[29:0]});
        end
        s_axi_rready = 1'b1;
        @(posedge aclk); #1;
        s_axi_rready = 1'b0;
        chk({tag, "_rdone"}, {31'h0, s_axi_rvalid}, 32'h0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_ready"}, {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h0);
        chk({tag, "_valid"}, {30'h0, s_axi_bvalid, s_axi_rvalid}, 32'h0);
        chk({tag, "_resp"}, {28'h0, s_axi_bresp, s_axi_rresp}, 32'h0);
        chk({tag, "_rdata"}, s_axi_rdata, 32'h0);
        chk({tag, "_pulses"}, {30'h0, start_pulse, stop_pulse}, 32'h0);
        chk_cfg(tag);
    endtask

    logic [31:0] old_v, rnd_d;
    logic [4:0]  rnd_a;
    logic [1:0]  resp_tmp;

    initial begin
        model_reset();
        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk_reset_state("reset");
        areset = 1'b0;
        @(posedge aclk); #1;

        // Same-cycle AW/W writes and readback
        do_write(5'h04, 32'h2222_2222, 4'hF, 0, 0, 0, "wr_delay");
        do_write(5'h08, 32'h0000_0002, 4'hF, 0, 0, 0, "wr_pkt");
        do_read(5'h04, 0, 0, "rd_delay");
        do_read(5'h08, 0, 2, "rd_pkt");

        // Skewed AW/W with a stalled B channel
        do_write(5'h04, 32'h1357_9BDF, 4'hF, 0, 3, 5, "aw_first");
        do_write(5'h04, 32'hA5A5_0F0F, 4'hF, 3, 0, 5, "w_first");
        do_read(5'h04, 0, 0, "rd_skew");

        // RUN start/stop pulses
        do_write(5'h00, 32'h0000_0015, 4'hF, 0, 0, 2, "run_on");
        do_write(5'h00, 32'h0000_0015, 4'hF, 0, 0, 2, "run_same");
        do_write(5'h00, 32'h0000_0000, 4'hF, 0, 0, 2, "run_off");

        // Lock rule while RUN=1 and lock-error sticky clear
        do_write(5'h00, 32'h0000_0001, 4'hF, 0, 0, 1, "lock_run");
        do_write(5'h08, 32'h0000_0010, 4'hF, 0, 0, 1, "lock_pkt");
        do_read(5'h08, 0, 0, "lock_rd_pkt");
        do_read(5'h0C, 0, 0, "lock_rd_sts");
        do_write(5'h0C, 32'h0000_0004, 4'hF, 0, 0, 0, "lock_clr");
        do_read(5'h0C, 0, 0, "lock_rd_clr");
        do_write(5'h00, 32'h0000_0000, 4'hF, 0, 0, 0, "lock_stop");

        // Read and write commit to the same address in one cycle
        old_v = m_delay;
        s_axi_awaddr = 5'h04; s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_araddr = 5'h04; s_axi_arvalid = 1'b1;
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
        chk("rw_same_valid", {30'h0, s_axi_bvalid, s_axi_rvalid}, 32'h3);
        chk("rw_same_rdata", s_axi_rdata, old_v);
        resp_tmp = model_write(5'h04, 32'hDEAD_BEEF, 4'hF);
        chk("rw_same_bresp", {30'h0, s_axi_bresp}, {30'h0, resp_tmp});
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        @(posedge aclk); #1;
        s_axi_bready = 1'b0; s_axi_rready = 1'b0;
        do_read(5'h04, 0, 0, "rw_same_after");

        // Overflow set coinciding with W1C of the same bit
        sts_overflow = 1'b1;
        @(posedge aclk); #1;
        sts_overflow = 1'b0;
        m_ovf = 1'b1;
        do_read(5'h0C, 0, 0, "ovf_set");
        s_axi_awaddr = 5'h0C; s_axi_wdata = 32'h0000_0002; s_axi_wstrb = 4'h1;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        sts_overflow = 1'b1;
        @(posedge aclk); #1;
        sts_overflow = 1'b0;
        resp_tmp = model_write(5'h0C, 32'h0000_0002, 4'h1);
        m_ovf = 1'b1;
        chk("ovf_w1c_bresp", {31'h0, s_axi_bvalid, s_axi_bresp}, {29'h0, 1'b1, resp_tmp});
        s_axi_bready = 1'b1;
        @(posedge aclk); #1;
        s_axi_bready = 1'b0;
        do_read(5'h0C, 0, 0, "ovf_set_wins");
        do_write(5'h0C, 32'h0000_0002, 4'h1, 0, 0, 0, "ovf_clr");
        do_read(5'h0C, 0, 0, "ovf_cleared");

        // Randomized traffic against the model
        for (int it = 0; it < 40; it++) begin
            int sel;
            sel = $urandom_range(0, 5);
            rnd_a = (sel < 4) ? 5'(sel * 4) : 5'(5'h10 + $urandom_range(0, 3) * 4);
            rnd_a[1:0] = 2'($urandom_range(0, 3));
            rnd_d = $urandom;
            sts_busy = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1)
                do_write(rnd_a, rnd_d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3), "rnd_wr");
            else
                do_read(rnd_a, $urandom_range(0, 3), $urandom_range(0, 3), "rnd_rd");
        end
        sts_busy = 1'b0;

        // Reset while a write response is pending
        do_write(5'h00, 32'h0000_0003, 4'hF, 0, 0, 0, "pre_rst");
        s_axi_awaddr = 5'h08; s_axi_wdata = 32'h0000_0077; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(posedge aclk); #1;
        chk("mid_rst_bvalid_before", {31'h0, s_axi_bvalid}, 32'h1);
        areset = 1'b1;
        @(posedge aclk); #1;
        model_reset();
        chk_reset_state("mid_rst");
        areset = 1'b0;
        @(posedge aclk); #1;
        chk("post_rst_ready", {29'h0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'h7);
        do_read(5'h0C, 0, 0, "post_rst_sts");

        // Byte strobes, PKT_LEN zero rule, unmapped read
        do_write(5'h04, 32'hFFFF_FFFF, 4'h1, 0, 0, 0, "strb");
        do_read(5'h04, 0, 0, "strb_rd");
        chk("strb_value", m_delay, 32'h0000_00FF);
        do_write(5'h08, 32'h0000_0000, 4'hF, 0, 0, 0, "pkt_zero");
        do_read(5'h08, 0, 0, "pkt_zero_rd");
        do_write(5'h14, 32'h1234_5678, 4'hF, 0, 0, 0, "unmapped_wr");
        do_read(5'h10, 0, 0, "unmapped_rd");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
